voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic note scheduler that shares a fixed pool of NVOICES synthesizer voices among incoming note-on/note-off events. Each accepted event is resolved to one voice: a free voice is assigned, a held note is retriggered, or the least-recently-allocated voice is stolen. Outputs drive each voice's 8-bit note index (`F_in`) and `key_on` gate directly. The block sits between the MIDI/keyboard front end and the voice array.

## Interface
- NVOICES, 4: number of voices managed (2..16).
- GAP, 16: cycles `key_on` is held low before re-asserting on retrigger or steal, so the ADSR restarts its attack (1..255).

Ports:
- Clk  in  1  system clock; one clock domain.
- Reset_n  in  1  asynchronous, active-low reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  block can accept an event; high only in IDLE.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  7  note number 0..127.
- all_off  in  1  panic: synchronous release of all voices.
- F_in_o  out  8*NVOICES  per-voice note index; voice v at [8v+7:8v]; bit 7 always 0.
- key_on_o  out  NVOICES  per-voice gate.
- active_cnt  out  $clog2(NVOICES+1)  number of voices with key_on=1.

## Operation
- States: IDLE, SCAN, DECIDE, GAP_WAIT.
- IDLE: ev_ready=1. Handshake on ev_valid & ev_ready latches ev_on/ev_note; go to SCAN.
- SCAN: one voice examined per cycle, index 0..NVOICES-1, tracking:
  - first voice with key_on=1 and note == ev_note (match);
  - first voice with key_on=0 and not reserved (free).
  After the last voice, go to DECIDE.
- DECIDE, note-on:
  - match found: clear key_on, keep note, go to GAP_WAIT (retrigger);
  - else free found: write note, set key_on, mark it most recent, go to IDLE;
  - else: select the victim (LRU rank NVOICES-1), clear key_on, write note, mark it most recent, go to GAP_WAIT (steal).
- DECIDE, note-off: if match found, clear key_on; F_in unchanged so the release tail keeps its pitch. If no match, drop the event. Go to IDLE.
- GAP_WAIT: counter runs GAP cycles, then sets key_on on the target voice and goes to IDLE.
- LRU: per-voice rank, width $clog2(NVOICES). On allocate of voice v, rank[v]=0 and every rank below old rank[v] increments. A retrigger also counts as an allocate. Ranks are always a permutation of 0..NVOICES-1.
- all_off: sampled in every state and takes priority over any event. Clears all key_on_o, aborts the operation in progress, goes to IDLE. F_in_o and ranks are unchanged. A handshake in the same cycle is discarded.
- Unsigned arithmetic throughout. The note compare uses 7 bits.

## Timing
- Reset values: key_on_o=0, F_in_o=0, rank[v]=v, state IDLE, ev_ready=1, active_cnt=0.
- Accept at cycle 0. SCAN occupies cycles 1..NVOICES. DECIDE is cycle NVOICES+1. Outputs update at the end of DECIDE.
- Free-voice note-on or note-off: ev_ready high again at cycle NVOICES+2.
- Retrigger or steal: key_on low for exactly GAP cycles after DECIDE. It rises and ev_ready returns in the same cycle, NVOICES+2+GAP.
- active_cnt is registered and follows key_on_o by 0 cycles, i.e. it is computed from the same next-state.
- Reset_n asserted mid-operation: all state returns to reset values immediately. The in-flight event is lost.

## Structure
- Shared package `synth_pkg`:
  - `alloc_state_t` enum (IDLE/SCAN/DECIDE/GAP_WAIT);
  - `NOTE_W`=7, `F_IN_W`=8;
  - `note_ev_t` struct {on, note}.
- Sub-module `lru_rank`: NVOICES rank registers with an allocate strobe/index and a victim-index output.
- The FSM, scan counter and gap counter live in the top module.

## Test plan
- Reset, then note-on 60 with NVOICES=4, GAP=16 -> voice 0 key_on=1, F_in=60 at cycle 6, ev_ready back at 6, active_cnt=1.
- Note-on 60, 62, 64, 67, then note-on 72 -> voice 0 (oldest) key_on low for 16 cycles, F_in=72, key_on re-asserted at cycle 22.
- Note-on 60 then note-on 60 again -> same voice retriggered, no second voice used, key_on low for exactly 16 cycles.
- Note-on 60, then note-off 61 -> no change; note-off 60 -> key_on=0, F_in stays 60, active_cnt=0.
- all_off asserted during GAP_WAIT of a steal -> all key_on=0 next cycle, state IDLE, the stolen voice is not re-gated.
- Reset_n pulsed low during SCAN -> outputs at reset values asynchronously; the next event is processed normally.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and widths for the synthesizer voice-control blocks.
package synth_pkg;

    localparam int NOTE_W = 7;
    localparam int F_IN_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DECIDE,
        GAP_WAIT
    } alloc_state_t;

    typedef struct packed {
        logic              on;
        logic [NOTE_W-1:0] note;
    } note_ev_t;

endpackage

// File: rtl/voice_allocator_lru_rank.sv
// Per-voice recency ranks: 0 = most recently allocated, NVOICES-1 = steal victim.
module lru_rank #(
    parameter int NVOICES = 4
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       alloc,
    input  logic [$clog2(NVOICES)-1:0] alloc_idx,
    output logic [$clog2(NVOICES)-1:0] victim_idx
);

    localparam int IDX_W = $clog2(NVOICES);

    logic [IDX_W-1:0] rank_q [NVOICES];
    logic [IDX_W-1:0] rank_d [NVOICES];

    always_comb begin
        rank_d     = rank_q;
        victim_idx = '0;
        for (int v = 0; v < NVOICES; v++) begin
            if (rank_q[v] == IDX_W'(NVOICES - 1)) begin
                victim_idx = IDX_W'(v);
            end
            // Only voices more recent than the allocated one age; the set stays a permutation.
            if (alloc) begin
                if (IDX_W'(v) == alloc_idx) begin
                    rank_d[v] = '0;
                end else if (rank_q[v] < rank_q[alloc_idx]) begin
                    rank_d[v] = rank_q[v] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int v = 0; v < NVOICES; v++) begin
                rank_q[v] <= IDX_W'(v);
            end
        end else begin
            rank_q <= rank_d;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Note-event scheduler: scans the voice pool, then assigns, retriggers or steals a voice.
//   state    | meaning
//   IDLE     | ev_ready high, waiting for an event
//   SCAN     | one voice per cycle, looking for matching and free voices
//   DECIDE   | apply assign / retrigger / steal / release
//   GAP_WAIT | target gate held low so the envelope restarts
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NVOICES = 4,
    parameter int GAP     = 16
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic                          ev_on,
    input  logic [NOTE_W-1:0]             ev_note,
    input  logic                          all_off,
    output logic [F_IN_W*NVOICES-1:0]     F_in_o,
    output logic [NVOICES-1:0]            key_on_o,
    output logic [$clog2(NVOICES+1)-1:0]  active_cnt
);

    localparam int IDX_W = $clog2(NVOICES);
    localparam int CNT_W = $clog2(NVOICES + 1);

    alloc_state_t      state_q, state_d;
    note_ev_t          ev_q, ev_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic              match_found_q, match_found_d;
    logic [IDX_W-1:0]  match_idx_q, match_idx_d;
    logic              free_found_q, free_found_d;
    logic [IDX_W-1:0]  free_idx_q, free_idx_d;
    logic [IDX_W-1:0]  target_q, target_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic [NOTE_W-1:0] note_q [NVOICES];
    logic [NOTE_W-1:0] note_d [NVOICES];
    logic [NVOICES-1:0] key_on_q, key_on_d;
    logic [CNT_W-1:0]  active_cnt_q, active_cnt_d;

    logic              alloc;
    logic [IDX_W-1:0]  alloc_idx;
    logic [IDX_W-1:0]  victim_idx;

    lru_rank #(.NVOICES(NVOICES)) u_lru_rank (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .alloc      (alloc),
        .alloc_idx  (alloc_idx),
        .victim_idx (victim_idx)
    );

    always_comb begin
        state_d       = state_q;
        ev_d          = ev_q;
        scan_idx_d    = scan_idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        target_d      = target_q;
        gap_cnt_d     = gap_cnt_q;
        note_d        = note_q;
        key_on_d      = key_on_q;
        alloc         = 1'b0;
        alloc_idx     = '0;

        case (state_q)
            IDLE: begin
                if (ev_valid) begin
                    ev_d          = '{on: ev_on, note: ev_note};
                    scan_idx_d    = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                if (!match_found_q && key_on_q[scan_idx_q] && note_q[scan_idx_q] == ev_q.note) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_idx_q;
                end
                if (!free_found_q && !key_on_q[scan_idx_q]) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx_q;
                end
                if (scan_idx_q == IDX_W'(NVOICES - 1)) begin
                    state_d = DECIDE;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            DECIDE: begin
                state_d = IDLE;
                if (ev_q.on) begin
                    alloc = 1'b1;
                    if (match_found_q) begin
                        alloc_idx               = match_idx_q;
                        key_on_d[match_idx_q]   = 1'b0;
                        target_d                = match_idx_q;
                        gap_cnt_d               = 8'(GAP - 1);
                        state_d                 = GAP_WAIT;
                    end else if (free_found_q) begin
                        alloc_idx               = free_idx_q;
                        note_d[free_idx_q]      = ev_q.note;
                        key_on_d[free_idx_q]    = 1'b1;
                    end else begin
                        alloc_idx               = victim_idx;
                        note_d[victim_idx]      = ev_q.note;
                        key_on_d[victim_idx]    = 1'b0;
                        target_d                = victim_idx;
                        gap_cnt_d               = 8'(GAP - 1);
                        state_d                 = GAP_WAIT;
                    end
                end else if (match_found_q) begin
                    key_on_d[match_idx_q] = 1'b0;
                end
            end
            GAP_WAIT: begin
                if (gap_cnt_q == 8'd0) begin
                    key_on_d[target_q] = 1'b1;
                    state_d            = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Panic wins over everything, including the write a DECIDE cycle would make.
        if (all_off) begin
            key_on_d = '0;
            note_d   = note_q;
            alloc    = 1'b0;
            state_d  = IDLE;
        end

        active_cnt_d = '0;
        for (int v = 0; v < NVOICES; v++) begin
            active_cnt_d = active_cnt_d + CNT_W'(key_on_d[v]);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            ev_q          <= '0;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            target_q      <= '0;
            gap_cnt_q     <= '0;
            for (int v = 0; v < NVOICES; v++) begin
                note_q[v] <= '0;
            end
            key_on_q      <= '0;
            active_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            ev_q          <= ev_d;
            scan_idx_q    <= scan_idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            target_q      <= target_d;
            gap_cnt_q     <= gap_cnt_d;
            note_q        <= note_d;
            key_on_q      <= key_on_d;
            active_cnt_q  <= active_cnt_d;
        end
    end

    always_comb begin
        ev_ready   = (state_q == IDLE);
        key_on_o   = key_on_q;
        active_cnt = active_cnt_q;
        for (int v = 0; v < NVOICES; v++) begin
            F_in_o[F_IN_W*v +: F_IN_W] = {1'b0, note_q[v]};
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator against a timestamp-based allocation model.
module tb_voice_allocator;

    localparam int NV  = 4;
    localparam int GAP = 16;
    localparam int CW  = $clog2(NV + 1);

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic            ev_valid = 1'b0;
    logic            ev_on = 1'b0;
    logic [6:0]      ev_note = '0;
    logic            all_off = 1'b0;
    logic            ev_ready;
    logic [8*NV-1:0] F_in_o;
    logic [NV-1:0]   key_on_o;
    logic [CW-1:0]   active_cnt;

    int checks = 0;
    int failures = 0;

    // Model: voice pitch, gate, and time of last allocation (oldest = smallest stamp).
    int m_note [NV];
    bit m_on [NV];
    int m_stamp [NV];
    int t_now;

    voice_allocator #(.NVOICES(NV), .GAP(GAP)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_on      (ev_on),
        .ev_note    (ev_note),
        .all_off    (all_off),
        .F_in_o     (F_in_o),
        .key_on_o   (key_on_o),
        .active_cnt (active_cnt)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_fin();
        logic [63:0] r = '0;
        for (int v = 0; v < NV; v++) r[8*v +: 8] = 8'(m_note[v] % 128);
        return r;
    endfunction

    function automatic logic [63:0] exp_keys();
        logic [63:0] r = '0;
        for (int v = 0; v < NV; v++) r[v] = m_on[v];
        return r;
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int v = 0; v < NV; v++) n += int'(m_on[v]);
        return n;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_note[v]  = 0;
            m_on[v]    = 0;
            m_stamp[v] = NV - 1 - v;
        end
        t_now = NV;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".f_in"},   64'(F_in_o),     exp_fin());
        chk({tag, ".key_on"}, 64'(key_on_o),   exp_keys());
        chk({tag, ".active"}, 64'(active_cnt), 64'(exp_cnt()));
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge Clk);
        while (!ev_ready && n < 400) begin
            @(negedge Clk);
            n++;
        end
        if (!ev_ready) chk("ready_timeout", 64'(ev_ready), 64'd1);
    endtask

    // One event end to end; abort_at >= 0 pulses all_off that many cycles into a gap.
    task automatic send_event(input bit on, input int note, input int abort_at);
        int match = -1;
        int free = -1;
        int tgt = -1;
        bit gap = 0;
        int cnt = 0;
        wait_ready();
        for (int v = 0; v < NV; v++) begin
            if (m_on[v] && m_note[v] == note && match < 0) match = v;
            if (!m_on[v] && free < 0) free = v;
        end
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = 7'(note);
        @(posedge Clk);
        @(negedge Clk);
        ev_valid = 1'b0;
        repeat (NV) @(posedge Clk);
        @(negedge Clk);
        chk("busy_in_decide", 64'(ev_ready), 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        if (on) begin
            if (match >= 0) begin
                tgt = match;
                gap = 1;
            end else if (free >= 0) begin
                m_note[free] = note;
                m_on[free]   = 1;
                m_stamp[free] = t_now++;
            end else begin
                tgt = 0;
                for (int v = 1; v < NV; v++) if (m_stamp[v] < m_stamp[tgt]) tgt = v;
                m_note[tgt] = note;
                gap = 1;
            end
            if (gap) begin
                m_on[tgt]    = 0;
                m_stamp[tgt] = t_now++;
            end
        end else if (match >= 0) begin
            m_on[match] = 0;
        end
        check_outputs("decide");
        chk("ready_after_decide", 64'(ev_ready), 64'(!gap));
        if (gap) begin
            while (!ev_ready && cnt < 300) begin
                if (cnt == abort_at) begin
                    all_off = 1'b1;
                    @(posedge Clk);
                    @(negedge Clk);
                    all_off = 1'b0;
                    for (int v = 0; v < NV; v++) m_on[v] = 0;
                    check_outputs("abort");
                    chk("abort.ready", 64'(ev_ready), 64'd1);
                    repeat (GAP + 2) @(negedge Clk);
                    chk("abort.no_regate", 64'(key_on_o), 64'd0);
                    return;
                end
                chk("gap_low", 64'(key_on_o[tgt]), 64'd0);
                @(posedge Clk);
                @(negedge Clk);
                cnt++;
            end
            chk("gap_len", 64'(cnt), 64'(GAP));
            m_on[tgt] = 1;
            check_outputs("regate");
        end
    endtask

    task automatic panic_with_handshake(input int note);
        wait_ready();
        all_off  = 1'b1;
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'(note);
        @(posedge Clk);
        @(negedge Clk);
        all_off  = 1'b0;
        ev_valid = 1'b0;
        for (int v = 0; v < NV; v++) m_on[v] = 0;
        chk("panic.ready", 64'(ev_ready), 64'd1);
        check_outputs("panic");
    endtask

    task automatic reset_during_scan();
        wait_ready();
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd50;
        @(posedge Clk);
        @(negedge Clk);
        ev_valid = 1'b0;
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        chk("async_reset.ready", 64'(ev_ready), 64'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge Clk);
        check_outputs("reset");
        chk("reset.ready", 64'(ev_ready), 64'd1);
        Reset_n = 1'b1;

        send_event(1, 60, -1);
        send_event(1, 60, -1);
        send_event(0, 61, -1);
        send_event(0, 60, -1);
        send_event(1, 60, -1);
        send_event(1, 62, -1);
        send_event(1, 64, -1);
        send_event(1, 67, -1);
        send_event(1, 72, -1);
        send_event(1, 74, 5);
        panic_with_handshake(80);
        send_event(1, 40, -1);
        reset_during_scan();
        send_event(1, 45, -1);
        send_event(1, 45, GAP - 1);

        for (int i = 0; i < 150; i++) begin
            int r = int'($urandom_range(0, 99));
            int n = 56 + int'($urandom_range(0, 8));
            if (r < 6) begin
                panic_with_handshake(n);
            end else begin
                send_event(r < 66, n, (r < 14) ? int'($urandom_range(0, GAP - 1)) : -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
